// File: rtl/disp_pkg.sv
// disp_pkg: shared types for the row scheduler and its engine slots.
// Holds the top and engine state encodings, the default column/disparity
// widths and the (col, disp) result record.
package disp_pkg;

  localparam int DEF_COL_BITS  = 6;
  localparam int DEF_DISP_BITS = 6;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_DONE
  } top_state_e;

  typedef enum logic [2:0] {
    E_IDLE,
    E_CLR,
    E_START,
    E_BUSY,
    E_HOLD
  } eng_state_e;

  typedef struct packed {
    logic [DEF_COL_BITS-1:0]  col;
    logic [DEF_DISP_BITS-1:0] disp;
  } disp_result_t;

endpackage

// File: rtl/disp_row_scheduler_if.sv
// disp_row_scheduler_if: in-order (col, disp) result stream with
// valid/ready backpressure. The scheduler is the master.
interface disp_row_scheduler_if
  import disp_pkg::*;
#(
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int DISP_BITS = DEF_DISP_BITS
);

  logic                 out_valid;
  logic                 out_ready;
  logic [COL_BITS-1:0]  out_col;
  logic [DISP_BITS-1:0] out_disp;
  logic                 out_last;

  modport master (
    output out_valid, out_col, out_disp, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_col, out_disp, out_last,
    output out_ready
  );

endinterface

// File: rtl/disp_eng_slot.sv
// disp_eng_slot: clear/start/busy/hold sequencer for one disparity engine,
// with the column and result holding registers. The watchdog counter is
// built only when DISP_SCHED_TIMEOUT_EN is defined.
module disp_eng_slot
  import disp_pkg::*;
#(
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int DISP_BITS = DEF_DISP_BITS,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch,
  input  logic [COL_BITS-1:0]  dispatch_col,
  input  logic                 drain,
  input  logic                 done,
  input  logic [DISP_BITS-1:0] disp_in,
  output logic                 can_dispatch,
  output logic                 res_avail,
  output logic [COL_BITS-1:0]  col,
  output logic [DISP_BITS-1:0] res_disp,
  output logic                 eng_clr,
  output logic                 eng_start,
  output logic                 timeout_evt
);

  eng_state_e           state_q, state_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [DISP_BITS-1:0] disp_q, disp_d;
  logic                 tmo_hit;

`ifdef DISP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == E_BUSY) && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counts cycles spent in E_BUSY and is cleared everywhere else.
  always_comb cnt_d = (state_q == E_BUSY) ? cnt_q + 1'b1 : '0;

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // A drained slot may take its next column in the same cycle it is emptied.
  assign can_dispatch = (state_q == E_IDLE) || ((state_q == E_HOLD) && drain);
  // The result is visible in the cycle it is captured so output latency is one edge.
  assign res_avail    = (state_q == E_HOLD) || ((state_q == E_BUSY) && (done || tmo_hit));
  assign res_disp     = (state_q == E_HOLD) ? disp_q : (done ? disp_in : '0);
  assign col          = col_q;
  assign eng_clr      = (state_q == E_CLR);
  assign eng_start    = (state_q == E_START);
  assign timeout_evt  = tmo_hit;

  // Next-state logic for the per-engine sequence; done is only honoured in E_BUSY.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    disp_d  = disp_q;
    case (state_q)
      E_IDLE: begin
        if (dispatch) begin
          state_d = E_CLR;
          col_d   = dispatch_col;
        end
      end
      E_CLR:   state_d = E_START;
      E_START: state_d = E_BUSY;
      E_BUSY: begin
        if (done) begin
          state_d = E_HOLD;
          disp_d  = disp_in;
        end else if (tmo_hit) begin
          state_d = E_HOLD;
          disp_d  = '0;
        end
      end
      E_HOLD: begin
        if (dispatch) begin
          state_d = E_CLR;
          col_d   = dispatch_col;
        end else if (drain) begin
          state_d = E_IDLE;
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  // State and holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) begin
      state_q <= E_IDLE;
      col_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: rtl/disp_row_scheduler.sv
// disp_row_scheduler: dispatches columns of a row round-robin to NUM_ENG
// disparity engines and drains their results in the same order, so the
// output stream is in column order without a reorder buffer.
// Optional watchdog: define DISP_SCHED_TIMEOUT_EN.
module disp_row_scheduler
  import disp_pkg::*;
#(
  parameter int NUM_ENG   = 2,
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int DISP_BITS = DEF_DISP_BITS,
  parameter int TIMEOUT   = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           row_start,
  input  logic [COL_BITS:0]              row_cols,
  output logic                           row_busy,
  output logic                           row_done,
  output logic [NUM_ENG-1:0]             eng_clr,
  output logic [NUM_ENG-1:0]             eng_start,
  output logic [NUM_ENG*COL_BITS-1:0]    eng_col,
  input  logic [NUM_ENG-1:0]             eng_done,
  input  logic [NUM_ENG*DISP_BITS-1:0]   eng_disp,
  disp_row_scheduler_if.master           out_if,
  output logic                           err_timeout
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  top_state_e           state_q, state_d;
  logic [COL_BITS:0]    row_cols_q, row_cols_d;
  logic [COL_BITS:0]    next_col_q, next_col_d;
  logic [PTR_W-1:0]     dsp_ptr_q, dsp_ptr_d;
  logic [PTR_W-1:0]     drn_ptr_q, drn_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [COL_BITS-1:0]  out_col_q, out_col_d;
  logic [DISP_BITS-1:0] out_disp_q, out_disp_d;
  logic                 out_last_q, out_last_d;

  logic [NUM_ENG-1:0]   slot_can_dsp, slot_avail, slot_tmo;
  logic [COL_BITS-1:0]  slot_col  [NUM_ENG];
  logic [DISP_BITS-1:0] slot_disp [NUM_ENG];

  logic                 active, dispatch_go, handshake, last_hs;
  logic [COL_BITS:0]    eff_cols;
  logic [PTR_W-1:0]     cand;

  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENG - 1)) ? '0 : p + 1'b1;
  endfunction

  // The first column dispatches on the same edge that accepts the row command.
  assign active      = ((state_q == T_IDLE) && row_start) || (state_q == T_RUN);
  assign eff_cols    = (state_q == T_IDLE) ? row_cols : row_cols_q;
  assign dispatch_go = active && slot_can_dsp[dsp_ptr_q] && (next_col_q < eff_cols);
  assign handshake   = out_valid_q && out_if.out_ready;
  assign last_hs     = handshake && out_last_q;
  assign cand        = handshake ? adv(drn_ptr_q) : drn_ptr_q;

  for (genvar i = 0; i < NUM_ENG; i++) begin : g_slot
    disp_eng_slot #(
      .COL_BITS (COL_BITS),
      .DISP_BITS(DISP_BITS),
      .TIMEOUT  (TIMEOUT)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .dispatch    (dispatch_go && (dsp_ptr_q == PTR_W'(i))),
      .dispatch_col(next_col_q[COL_BITS-1:0]),
      .drain       (handshake && (drn_ptr_q == PTR_W'(i))),
      .done        (eng_done[i]),
      .disp_in     (eng_disp[i*DISP_BITS +: DISP_BITS]),
      .can_dispatch(slot_can_dsp[i]),
      .res_avail   (slot_avail[i]),
      .col         (slot_col[i]),
      .res_disp    (slot_disp[i]),
      .eng_clr     (eng_clr[i]),
      .eng_start   (eng_start[i]),
      .timeout_evt (slot_tmo[i])
    );
    assign eng_col[i*COL_BITS +: COL_BITS] = slot_col[i];
  end

  // Top FSM, column counter and both round-robin pointers.
  always_comb begin
    state_d    = state_q;
    row_cols_d = row_cols_q;
    next_col_d = next_col_q;
    dsp_ptr_d  = dsp_ptr_q;
    drn_ptr_d  = drn_ptr_q;
    if (dispatch_go) begin
      next_col_d = next_col_q + 1'b1;
      dsp_ptr_d  = adv(dsp_ptr_q);
    end
    if (handshake) drn_ptr_d = adv(drn_ptr_q);
    case (state_q)
      T_IDLE: begin
        if (row_start) begin
          row_cols_d = row_cols;
          state_d    = (row_cols == '0) ? T_DONE : T_RUN;
        end
      end
      T_RUN: if (last_hs) state_d = T_DONE;
      T_DONE: begin
        state_d    = T_IDLE;
        next_col_d = '0;
        dsp_ptr_d  = '0;
        drn_ptr_d  = '0;
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Output register: reload from the next slot in drain order whenever empty or accepted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_disp_d  = out_disp_q;
    out_last_d  = out_last_q;
    if (!out_valid_q || handshake) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      // The slot being drained still reads as held this cycle, so it is excluded.
      if ((state_q == T_RUN) && !last_hs && slot_avail[cand] &&
          !(handshake && (cand == drn_ptr_q))) begin
        out_valid_d = 1'b1;
        out_col_d   = slot_col[cand];
        out_disp_d  = slot_disp[cand];
        out_last_d  = ({1'b0, slot_col[cand]} == (row_cols_q - 1'b1));
      end
    end
  end

  // Top-level registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= T_IDLE;
      row_cols_q  <= '0;
      next_col_q  <= '0;
      dsp_ptr_q   <= '0;
      drn_ptr_q   <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_disp_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cols_q  <= row_cols_d;
      next_col_q  <= next_col_d;
      dsp_ptr_q   <= dsp_ptr_d;
      drn_ptr_q   <= drn_ptr_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_disp_q  <= out_disp_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef DISP_SCHED_TIMEOUT_EN
  logic err_q;

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (|slot_tmo);
  end

  assign err_timeout = err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = |slot_tmo;
  assign err_timeout = 1'b0;
`endif

  assign row_busy         = (state_q == T_RUN);
  assign row_done         = (state_q == T_DONE);
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_col   = out_col_q;
  assign out_if.out_disp  = out_disp_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_disp_row_scheduler.sv
// tb_disp_row_scheduler: self-checking bench for disp_row_scheduler with a
// behavioural engine model, a result scoreboard, a table of row vectors and
// hand-written sequences for latency, stall, empty row, reset and timeout.
module tb_disp_row_scheduler;
  import disp_pkg::*;

  localparam int NE = 2;
  localparam int CB = DEF_COL_BITS;
  localparam int DB = DEF_DISP_BITS;

  typedef struct packed {
    disp_result_t r;
    logic         last;
  } exp_t;

  typedef struct {
    int cols;
    int lat0;
    int lat1;
    int exp_nout;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              row_start;
  logic [CB:0]       row_cols;
  logic              row_busy, row_done, err_timeout;
  logic [NE-1:0]     eng_clr, eng_start, eng_done;
  logic [NE*CB-1:0]  eng_col;
  logic [NE*DB-1:0]  eng_disp;

  disp_row_scheduler_if #(.COL_BITS(CB), .DISP_BITS(DB)) out_if ();

  disp_row_scheduler #(
    .NUM_ENG(NE), .COL_BITS(CB), .DISP_BITS(DB), .TIMEOUT(64)
  ) u_dut (
    .clk(clk), .rst(rst), .row_start(row_start), .row_cols(row_cols),
    .row_busy(row_busy), .row_done(row_done),
    .eng_clr(eng_clr), .eng_start(eng_start), .eng_col(eng_col),
    .eng_done(eng_done), .eng_disp(eng_disp),
    .out_if(out_if), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0, n_done = 0, n_clr = 0, n_start = 0, n_valid = 0;
  int   lat [NE];
  int   tmo_eng = -1;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DB-1:0] eng_result(input int col);
    return DB'((col * 7 + 3) % 64);
  endfunction

  function automatic logic [DB-1:0] exp_disp(input int col);
    if (tmo_eng >= 0 && (col % NE) == tmo_eng) return '0;
    return eng_result(col);
  endfunction

  // Engine model: done level rises lat[i] cycles after start, drops on clear.
  initial begin
    int m_cnt [NE];
    int m_col [NE];
    eng_done = '0;
    eng_disp = '0;
    for (int i = 0; i < NE; i++) begin m_cnt[i] = -1; m_col[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
        if (eng_clr[i]) begin
          eng_done[i] = 1'b0;
          m_cnt[i]    = -1;
        end else if (eng_start[i]) begin
          m_cnt[i] = lat[i];
          m_col[i] = int'(eng_col[i*CB +: CB]);
        end else if (m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
        if (m_cnt[i] == 0) begin
          eng_done[i]            = 1'b1;
          eng_disp[i*DB +: DB]   = eng_result(m_col[i]);
          m_cnt[i]               = -1;
        end
      end
    end
  end

  // Monitor: scoreboard pops on handshake, stall stability, row_done placement.
  initial begin
    logic          prev_stall, prev_last_hs;
    logic [CB-1:0] prev_col;
    logic [DB-1:0] prev_disp;
    exp_t          e;
    prev_stall = 1'b0; prev_last_hs = 1'b0; prev_col = '0; prev_disp = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
      end else begin
        if (prev_last_hs) check("row_done_after_last", 32'(row_done), 32'd1);
        if (prev_stall) begin
          check("stall_valid", 32'(out_if.out_valid), 32'd1);
          check("stall_col", 32'(out_if.out_col), 32'(prev_col));
          check("stall_disp", 32'(out_if.out_disp), 32'(prev_disp));
        end
        n_clr   += $countones(eng_clr);
        n_start += $countones(eng_start);
        if (out_if.out_valid) n_valid++;
        if (row_done) n_done++;
        if (out_if.out_valid && out_if.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_col", 32'(out_if.out_col), 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("out_col", 32'(out_if.out_col), 32'(e.r.col));
            check("out_disp", 32'(out_if.out_disp), 32'(e.r.disp));
            check("out_last", 32'(out_if.out_last), 32'(e.last));
          end
          n_out++;
        end
        prev_stall   = out_if.out_valid && !out_if.out_ready;
        prev_col     = out_if.out_col;
        prev_disp    = out_if.out_disp;
        prev_last_hs = out_if.out_valid && out_if.out_ready && out_if.out_last;
      end
    end
  end

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic start_row(input int cols);
    exp_t e;
    @(negedge clk);
    row_start = 1'b1;
    row_cols  = (CB+1)'(cols);
    for (int c = 0; c < cols; c++) begin
      e.r.col  = CB'(c);
      e.r.disp = exp_disp(c);
      e.last   = (c == cols - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    row_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (row_done) break;
      @(negedge clk);
    end
    check("row_done_seen", 32'(row_done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(row_busy), 32'd0);
    check({tag, "_done"}, 32'(row_done), 32'd0);
    check({tag, "_clr_start"}, 32'({eng_clr, eng_start}), 32'd0);
    check({tag, "_col"}, 32'(eng_col), 32'd0);
    check({tag, "_valid"}, 32'(out_if.out_valid), 32'd0);
    check({tag, "_payload"}, 32'({out_if.out_col, out_if.out_disp, out_if.out_last}), 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   done0, out0, clr0, valid0, start0;
    vecs[0] = '{cols: 5,  lat0: 20, lat1: 20, exp_nout: 5};
    vecs[1] = '{cols: 2,  lat0: 40, lat1: 10, exp_nout: 2};
    vecs[2] = '{cols: 7,  lat0: 3,  lat1: 15, exp_nout: 7};
    vecs[3] = '{cols: 1,  lat0: 5,  lat1: 5,  exp_nout: 1};
    vecs[4] = '{cols: 64, lat0: 2,  lat1: 4,  exp_nout: 64};

    rst = 1'b1; row_start = 1'b0; row_cols = '0; out_if.out_ready = 1'b1;
    lat[0] = 20; lat[1] = 20;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Dispatch latency: clear/col of engine 0 at t+1, start 0 and clear 1 at t+2.
    done0 = n_done; out0 = n_out;
    start_row(3);
    check("lat_busy", 32'(row_busy), 32'd1);
    check("lat_clr_t1", 32'(eng_clr), 32'b01);
    check("lat_col0", 32'(eng_col[CB-1:0]), 32'd0);
    @(negedge clk);
    check("lat_start_t2", 32'(eng_start), 32'b01);
    check("lat_clr_t2", 32'(eng_clr), 32'b10);
    check("lat_col1", 32'(eng_col[2*CB-1:CB]), 32'd1);
    wait_done(1000);
    check("lat_nout", 32'(n_out - out0), 32'd3);
    check("lat_ndone", 32'(n_done - done0), 32'd1);
    check("lat_busy_after", 32'(row_busy), 32'd0);

    // Table-driven rows with varying lengths and engine latencies.
    for (int v = 0; v < 5; v++) begin
      done0 = n_done; out0 = n_out;
      lat[0] = vecs[v].lat0; lat[1] = vecs[v].lat1;
      start_row(vecs[v].cols);
      wait_done(4000);
      check("tbl_nout", 32'(n_out - out0), 32'(vecs[v].exp_nout));
      check("tbl_ndone", 32'(n_done - done0), 32'd1);
      check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Backpressure: hold ready low for 30 cycles after the first valid.
    lat[0] = 20; lat[1] = 20;
    done0 = n_done; out0 = n_out; clr0 = n_clr;
    out_if.out_ready = 1'b0;
    start_row(5);
    for (int k = 0; k < 200; k++) begin
      if (out_if.out_valid) break;
      @(negedge clk);
    end
    check("stall_first_valid", 32'(out_if.out_valid), 32'd1);
    check("stall_first_col", 32'(out_if.out_col), 32'd0);
    repeat (30) @(negedge clk);
    check("stall_eng0_hold", 32'(u_dut.g_slot[0].u_slot.state_q), 32'(E_HOLD));
    check("stall_eng1_hold", 32'(u_dut.g_slot[1].u_slot.state_q), 32'(E_HOLD));
    check("stall_no_third", 32'(n_clr - clr0), 32'd2);
    check("stall_no_out", 32'(n_out - out0), 32'd0);
    out_if.out_ready = 1'b1;
    wait_done(1000);
    check("stall_nout", 32'(n_out - out0), 32'd5);
    check("stall_ndone", 32'(n_done - done0), 32'd1);

    // Empty row: immediate row_done, no engine activity, no output.
    done0 = n_done; clr0 = n_clr; start0 = n_start; valid0 = n_valid;
    start_row(0);
    check("zero_done_t1", 32'(row_done), 32'd1);
    check("zero_busy_t1", 32'(row_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("zero_ndone", 32'(n_done - done0), 32'd1);
    check("zero_clr", 32'(n_clr - clr0), 32'd0);
    check("zero_start", 32'(n_start - start0), 32'd0);
    check("zero_valid", 32'(n_valid - valid0), 32'd0);

    // Reset mid-row aborts; a following 3-column row produces cols 0..2 only.
    done0 = n_done;
    start_row(5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out0 = n_out;
    repeat (30) @(negedge clk);
    check("midrst_no_out", 32'(n_out - out0), 32'd0);
    check("midrst_no_done", 32'(n_done - done0), 32'd0);
    done0 = n_done;
    start_row(3);
    wait_done(1000);
    check("midrst_nout", 32'(n_out - out0), 32'd3);
    check("midrst_ndone", 32'(n_done - done0), 32'd1);
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef DISP_SCHED_TIMEOUT_EN
    // Engine 0 never completes: col 0 comes out as 0 and the flag latches.
    check("tmo_err_before", 32'(err_timeout), 32'd0);
    tmo_eng = 0; lat[0] = -1; lat[1] = 5;
    done0 = n_done; out0 = n_out;
    start_row(2);
    wait_done(2000);
    check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_nout", 32'(n_out - out0), 32'd2);
    check("tmo_ndone", 32'(n_done - done0), 32'd1);
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", 32'(err_timeout), 32'd1);
    tmo_eng = -1;
`else
    check("err_timeout_tied", 32'(err_timeout), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/disp_row_scheduler.md
# disp_row_scheduler

Row-level scheduler for the SAD disparity engines. Accepts a row command, dispatches one column index per engine (clear, start, hold), collects each engine's disparity result and emits an in-order `(col, disp)` stream with valid/ready backpressure. Sits between the row line buffer / control CPU and `NUM_ENG` instances of the disparity engine. Engines do not self-restart after done, so this block owns their per-pixel clear and start sequencing.

## Interface
- `NUM_ENG`, 2: number of disparity engines driven; power of two, 1..8.
- `COL_BITS`, 6: width of a column index (`$clog2(IMG_W)`).
- `DISP_BITS`, 6: width of an engine disparity result.
- `TIMEOUT`, 4096: watchdog limit in cycles, used only with `DISP_SCHED_TIMEOUT_EN`.
- `clk` in 1: the single clock.
- `rst` in 1: reset. Reset is synchronous and active-high.
- `row_start` in 1: one-cycle row command; sampled only in IDLE.
- `row_cols` in COL_BITS+1: number of columns to compute (0..2^COL_BITS); sampled with `row_start`.
- `row_busy` out 1: high from the cycle after an accepted `row_start` until `row_done`.
- `row_done` out 1: one-cycle pulse when the row is complete.
- `eng_clr` out NUM_ENG: per-engine one-cycle clear pulse; drives the engine reset.
- `eng_start` out NUM_ENG: per-engine one-cycle start pulse; drives `input_ready`.
- `eng_col` out NUM_ENG*COL_BITS: per-engine column index. Held stable from clear until that engine's result is drained.
- `eng_done` in NUM_ENG: per-engine done level. Stays high until cleared.
- `eng_disp` in NUM_ENG*DISP_BITS: per-engine disparity; valid while done.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_col` out COL_BITS, `out_disp` out DISP_BITS, `out_last` out 1: result payload. `out_last` marks column `row_cols-1`.
- `err_timeout` out 1: sticky timeout flag; constant 0 without the macro.

## Operation
- Top FSM:
  - IDLE → RUN on `row_start` when `row_cols != 0`.
  - IDLE → DONE on `row_start` when `row_cols == 0`.
  - RUN → DONE when the last result handshakes.
  - DONE → IDLE unconditionally. DONE lasts 1 cycle and `row_done` = 1 in it.
  - `row_start` outside IDLE is ignored.
- Per-engine FSM (E_IDLE, E_CLR, E_START, E_BUSY, E_HOLD):
  - E_IDLE → E_CLR when dispatched. `eng_col[i]` is loaded from `next_col` and `next_col` increments.
  - E_CLR: `eng_clr[i]` = 1 for 1 cycle → E_START.
  - E_START: `eng_start[i]` = 1 for 1 cycle → E_BUSY.
  - E_BUSY: the first cycle `eng_done[i]` is high, capture `eng_disp[i]` → E_HOLD.
  - E_HOLD → E_IDLE when drained.
- Dispatch pointer `dsp_ptr` cycles 0..NUM_ENG-1. One dispatch per cycle at most, only when `engine[dsp_ptr]` is in E_IDLE and `next_col < row_cols`. The pointer advances on dispatch (wraps).
- Drain pointer `drn_ptr` follows the same round-robin order. Engine i therefore always carries columns i, i+NUM_ENG, …, so output is in column order without a reorder buffer.
- `out_*` are registered from the held result of `engine[drn_ptr]`:
  - Payload is stable while `out_valid && !out_ready`.
  - On handshake, `drn_ptr` advances and that engine returns to E_IDLE. It is eligible for dispatch the same cycle.
- Disparity passes through unmodified; width is exactly DISP_BITS.

## Timing
- Reset values: all outputs 0, FSMs in IDLE/E_IDLE, pointers 0, `next_col` 0.
- `rst` mid-row aborts immediately: no `row_done`, no further output.
- `row_start` sampled at edge t:
  - `row_busy`, `eng_clr[0]` and `eng_col[0]` = 0 in cycle t+1.
  - `eng_start[0]` in cycle t+2.
  - `eng_clr[1]` in cycle t+2.
- `eng_done[i]` first high at edge d → result captured at d. `out_valid` high in cycle d+1 if `drn_ptr == i`.
- Back-to-back handshakes give 1 result per cycle when results are ready.
- `row_done` occurs the cycle after the `out_last` handshake. `row_start` is accepted again the following cycle.
- A done arriving while the engine is not in E_BUSY (stale level) is ignored.

## Configuration
- `DISP_SCHED_TIMEOUT_EN` defined:
  - Each engine has a counter running in E_BUSY.
  - On reaching TIMEOUT, the engine goes to E_HOLD with disparity 0 and `err_timeout` sets. It clears only on `rst`.
- Macro absent: no counters; an engine waits indefinitely in E_BUSY; `err_timeout` is tied to 0.

## Structure
- Shared package `disp_pkg`:
  - top and engine state encodings;
  - `COL_BITS` and `DISP_BITS` defaults;
  - the disparity result struct `{col, disp}`.
- One natural sub-module, `disp_eng_slot`: the per-engine FSM, column / result holding registers and optional watchdog, generated NUM_ENG times. The top level holds the pointers, the top FSM and the output register.

## Test plan
- NUM_ENG=2, `row_cols`=5, engine model done 20 cycles after start, `out_ready`=1 → `out_col` 0,1,2,3,4 in order with matching disparities; `out_last` on col 4; one `row_done`.
- Same row, `out_ready` low for 30 cycles after the first valid → payload col 0 held stable; engines 0/1 stay in E_HOLD; no third dispatch until col 0 drains.
- Engine 1 completes before engine 0 (latencies 40/10) → output order still col 0 then col 1.
- `row_cols`=0 → `row_done` at t+1; no `eng_clr`, `eng_start` or `out_valid`.
- `rst` asserted mid-row, then `row_start` with `row_cols`=3 → all outputs 0 after reset; new row yields cols 0..2 only.
- With `DISP_SCHED_TIMEOUT_EN`, TIMEOUT=64, engine 0 never done → `out_disp`=0 for col 0; `err_timeout`=1; row completes.
